// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store,
// with a fixed-latency access, byte/half/word lane steering and pipeline stalls.
module mem_port_arbiter #(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        misalign,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned CW = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_mem_q, last_mem_d;
    logic          port_mem_q, port_mem_d;
    logic          we_q, we_d;
    logic          mis_q, mis_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic          grant_mem;
    logic          misaligned;
    logic [31:0]   steered;
    logic [3:0]    we_mask;

    // MEM wins a tie unless it was the last port served.
    always_comb begin
        grant_mem  = mem_req & (~if_req | ~last_mem_q);
        misaligned = grant_mem &
                     ((((mem_sel == 2'b00) || (mem_sel == 2'b11)) && (mem_addr[1:0] != 2'b00)) ||
                      ((mem_sel == 2'b01) && mem_addr[0]));
    end

    always_comb begin
        case (sel_q)
            2'b01:   steered = {16'h0000, addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
            2'b10:   steered = {24'h000000, ram_rdata[{addr_q[1:0], 3'b000} +: 8]};
            default: steered = ram_rdata;
        endcase
    end

    always_comb begin
        case (sel_q)
            2'b01: begin
                we_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                we_mask   = 4'b0001 << addr_q[1:0];
                ram_wdata = {4{wdata_q[7:0]}};
            end
            default: begin
                we_mask   = 4'b1111;
                ram_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_mem_d  = last_mem_q;
        port_mem_d  = port_mem_q;
        we_d        = we_q;
        mis_d       = mis_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    port_mem_d = grant_mem;
                    last_mem_d = grant_mem;
                    addr_d     = grant_mem ? mem_addr : if_addr;
                    we_d       = grant_mem & mem_we;
                    sel_d      = grant_mem ? mem_sel : 2'b00;
                    wdata_d    = mem_wdata;
                    cnt_d      = CW'(RAM_LAT);
                    mis_d      = misaligned;
                    if (misaligned) begin
                        mem_rdata_d = '0;
                        state_d     = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (port_mem_q) mem_rdata_d = steered;
                    else            if_rdata_d  = steered;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_mem_q  <= 1'b0;
            port_mem_q  <= 1'b0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_mem_q  <= last_mem_d;
            port_mem_q  <= port_mem_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // RAM controls decode from the state register so reset kills them immediately.
    always_comb begin
        ram_en    = (state_q == ACCESS);
        ram_we    = (ram_en && we_q) ? we_mask : 4'b0000;
        ram_addr  = {addr_q[31:2], 2'b00};
        if_ready  = (state_q == DONE) & ~port_mem_q;
        mem_ready = (state_q == DONE) & port_mem_q;
        misalign  = mem_ready & mis_q;
        if_rdata  = if_rdata_q;
        mem_rdata = mem_rdata_q;
        stall_if  = rst_n & if_req & ~if_ready;
        stall_mem = rst_n & mem_req & ~mem_ready;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// responses; a negedge monitor pops and compares on every ready pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        misalign;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        stall_if;
    logic        stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .misalign(misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Extra instances used only for latency at other RAM_LAT values.
    logic        l1_req, l4_req;
    logic        l1_ready, l4_ready, l1_mready, l4_mready, l1_mis, l4_mis;
    logic        l1_en, l4_en, l1_sif, l4_sif, l1_smem, l4_smem;
    logic [3:0]  l1_we, l4_we;
    logic [31:0] l1_rdata, l4_rdata, l1_mrdata, l4_mrdata;
    logic [31:0] l1_addr, l4_addr, l1_wdata, l4_wdata;
    logic [31:0] lx_if_addr = 32'h0000_0040;

    mem_port_arbiter #(.RAM_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l1_req), .if_addr(lx_if_addr), .if_rdata(l1_rdata), .if_ready(l1_ready),
        .mem_req(1'b0), .mem_we(1'b0), .mem_sel(2'b00), .mem_addr(32'h0),
        .mem_wdata(32'h0), .mem_rdata(l1_mrdata), .mem_ready(l1_mready), .misalign(l1_mis),
        .ram_en(l1_en), .ram_we(l1_we), .ram_addr(l1_addr), .ram_wdata(l1_wdata),
        .ram_rdata(l1_addr ^ 32'h5A5A_5A5A), .stall_if(l1_sif), .stall_mem(l1_smem)
    );

    mem_port_arbiter #(.RAM_LAT(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l4_req), .if_addr(lx_if_addr), .if_rdata(l4_rdata), .if_ready(l4_ready),
        .mem_req(1'b0), .mem_we(1'b0), .mem_sel(2'b00), .mem_addr(32'h0),
        .mem_wdata(32'h0), .mem_rdata(l4_mrdata), .mem_ready(l4_mready), .misalign(l4_mis),
        .ram_en(l4_en), .ram_we(l4_we), .ram_addr(l4_addr), .ram_wdata(l4_wdata),
        .ram_rdata(l4_addr ^ 32'h5A5A_5A5A), .stall_if(l4_sif), .stall_mem(l4_smem)
    );

    // RAM model: data is only valid in the RAM_LAT-th enabled cycle, writes land then too.
    logic [31:0] ram [0:255];
    logic [2:0]  en_cnt;
    logic        mem_init = 1'b0;

    assign ram_rdata = (ram_en && en_cnt == 3'd1) ? ram[ram_addr[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      en_cnt <= 3'd0;
        else if (ram_en) en_cnt <= en_cnt + 3'd1;
        else             en_cnt <= 3'd0;
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A5_0000 | i;
            ram[16]  <= 32'h2402_0005;
            ram[17]  <= 32'h00A0_0093;
            ram[18]  <= 32'h00B0_0113;
            ram[32]  <= 32'h89AB_CDEF;
            ram[64]  <= 32'hCAFE_F00D;
            ram[65]  <= 32'h1357_9BDF;
            ram[128] <= 32'h1122_3344;
            ram[192] <= 32'h5566_7788;
            mem_init <= 1'b1;
        end else if (ram_en && en_cnt == 3'd1) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_if = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_mem, input logic [31:0] rdata, input logic mis, input logic chk);
        exp_t e;
        e.is_mem = is_mem; e.rdata = rdata; e.mis = mis; e.chk_data = chk;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_if = 32'h0;
        end else begin
            if (misalign && !mem_ready) check("misalign_alone", misalign, 0);
            if (if_ready || mem_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", {30'h0, if_ready, mem_ready}, 0);
                end else begin
                    e = sb.pop_front();
                    check("ready_port", mem_ready, e.is_mem);
                    check("single_ready", if_ready & mem_ready, 0);
                    if (e.is_mem) begin
                        if (e.chk_data) check("mem_rdata", mem_rdata, e.rdata);
                        check("misalign", misalign, e.mis);
                        check("if_rdata_hold", if_rdata, last_if);
                    end else begin
                        check("if_rdata", if_rdata, e.rdata);
                        check("if_misalign", misalign, 0);
                        last_if = e.rdata;
                    end
                end
            end
        end
    end

    logic [3:0]  cap_we;
    logic [31:0] cap_addr, cap_wdata;
    int          en_cycles, lat;

    task automatic if_txn(input logic [31:0] addr);
        bit got = 0;
        if_req = 1'b1; if_addr = addr;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_ready) begin got = 1; break; end
        end
        if (!got) check("if_timeout", 0, 1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_txn(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bit got = 0;
        mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
        en_cycles = 0; lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ram_en) begin
                if (en_cycles == 0) begin cap_we = ram_we; cap_addr = ram_addr; cap_wdata = ram_wdata; end
                en_cycles++;
            end
            if (mem_ready) begin got = 1; lat = k; break; end
        end
        if (!got) check("mem_timeout", 0, 1);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic lat_check(input int which, input int exp_lat);
        bit got = 0;
        int l = -1;
        @(posedge clk); #1;
        if (which == 1) l1_req = 1'b1; else l4_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((which == 1 && l1_ready) || (which == 4 && l4_ready)) begin
                got = 1; l = k;
                check("lat_rdata", (which == 1) ? l1_rdata : l4_rdata, 32'h5A5A_5A1A);
                break;
            end
        end
        if (!got) check("lat_timeout", 0, 1);
        check(which == 1 ? "latency_lat1" : "latency_lat4", l, exp_lat);
        @(posedge clk); #1;
        l1_req = 1'b0; l4_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 2'b00; mem_addr = '0; mem_wdata = '0;
        l1_req = 1'b0; l4_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall_if", stall_if, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_rdata", if_rdata | mem_rdata, 0);
        if_req = 1'b0;
        rst_n = 1'b1;

        // Single fetch with cycle-by-cycle observation.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        push(1'b0, 32'h2402_0005, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_c0_stall_if", stall_if, 1);
        check("t1_c0_ram_en", ram_en, 0);
        @(negedge clk);
        check("t1_c1_ram_en", ram_en, 1);
        check("t1_c1_ram_addr", ram_addr, 32'h40);
        check("t1_c1_ram_we", ram_we, 0);
        check("t1_c1_stall_if", stall_if, 1);
        @(negedge clk);
        check("t1_c2_ram_en", ram_en, 1);
        check("t1_c2_stall_if", stall_if, 1);
        @(negedge clk);
        check("t1_c3_if_ready", if_ready, 1);
        check("t1_c3_stall_if", stall_if, 0);
        check("t1_c3_ram_en", ram_en, 0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("t1_c4_if_ready", if_ready, 0);

        // Contention: MEM first (last_mem=0), then alternation.
        push(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
        push(1'b0, 32'h00A0_0093, 1'b0, 1'b1);
        push(1'b1, 32'h1357_9BDF, 1'b0, 1'b1);
        push(1'b0, 32'h00B0_0113, 1'b0, 1'b1);
        @(posedge clk); #1;
        fork
            begin if_txn(32'h44); if_txn(32'h48); end
            begin mem_txn(1'b0, 2'b00, 32'h100, 32'h0); mem_txn(1'b0, 2'b00, 32'h104, 32'h0); end
        join

        // Byte store and byte/half loads.
        push(1'b1, 32'h0, 1'b0, 1'b0);
        mem_txn(1'b1, 2'b10, 32'h203, 32'h1234_56AB);
        check("sb_ram_we", cap_we, 4'b1000);
        check("sb_ram_addr", cap_addr, 32'h200);
        check("sb_ram_wdata", cap_wdata, 32'hABAB_ABAB);
        check("sb_en_cycles", en_cycles, 2);
        check("sb_latency", lat, 3);
        push(1'b1, 32'h0000_00AB, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b10, 32'h203, 32'h0);
        push(1'b1, 32'h0000_0033, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b10, 32'h201, 32'h0);
        push(1'b1, 32'h0000_AB22, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b01, 32'h202, 32'h0);

        // Half store, misaligned accesses, sel=11 as word.
        push(1'b1, 32'h0, 1'b0, 1'b0);
        mem_txn(1'b1, 2'b01, 32'h302, 32'hFFFF_1234);
        check("sh_ram_we", cap_we, 4'b1100);
        check("sh_ram_wdata", cap_wdata, 32'h1234_1234);
        push(1'b1, 32'h0, 1'b1, 1'b1);
        mem_txn(1'b0, 2'b00, 32'h302, 32'h0);
        check("mis_en_cycles", en_cycles, 0);
        check("mis_latency", lat, 1);
        push(1'b1, 32'h0000_1234, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b01, 32'h302, 32'h0);
        push(1'b1, 32'h0000_7788, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b01, 32'h300, 32'h0);
        push(1'b1, 32'h0, 1'b1, 1'b1);
        mem_txn(1'b0, 2'b01, 32'h301, 32'h0);
        push(1'b1, 32'h1234_7788, 1'b0, 1'b1);
        mem_txn(1'b0, 2'b11, 32'h300, 32'h0);

        // Reset during the second ACCESS cycle of a store aborts it.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b00; mem_addr = 32'h80; mem_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_c1_ram_en", ram_en, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ram_en", ram_en, 0);
        check("rst_mid_ram_we", ram_we, 0);
        check("rst_mid_stall_mem", stall_mem, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_ready", mem_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 32'h89AB_CDEF, 1'b0, 1'b1);
        @(posedge clk); #1;
        mem_txn(1'b0, 2'b00, 32'h80, 32'h0);
        check("post_rst_latency", lat, 3);

        lat_check(1, 2);
        lat_check(4, 5);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
